// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the divider scheduler slice: default geometry
// (requester count, operand width, divider timeout) and the scheduler FSM
// state type.
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int unsigned N_REQ_DEF   = 4;   // number of requesters
    localparam int unsigned W_DEF       = 7;   // operand width
    localparam int unsigned TIMEOUT_DEF = 16;  // max WAIT cycles for div_done

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Search starts at i_ptr and wraps, so the
// requester at i_ptr has the highest priority this cycle.
//
// Ports:
//   i_req   [N-1:0]  request vector
//   i_ptr   [IW-1:0] search start index (must be < N)
//   o_grant [N-1:0]  one-hot grant (all zero when no request)
//   o_idx   [IW-1:0] index of the granted requester (0 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    always_comb begin
        logic          found;
        int unsigned   pos;
        logic [IW-1:0] pidx;
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        pos     = 0;
        pidx    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // Modular walk from the pointer without a divider.
            pos = 32'(i_ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pidx = IW'(pos);
            if (!found && i_req[pidx]) begin
                found         = 1'b1;
                o_grant[pidx] = 1'b1;
                o_idx         = pidx;
            end
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// -----------------------------------------------------------------------------
// div_scheduler
// Shares one external sequential divider among N_REQ requesters. One request
// is in flight at a time: IDLE picks a requester round-robin, ISSUE pulses
// div_start, WAIT waits for div_done (bounded by TIMEOUT), RESP holds the
// response until the consumer takes it. Divide-by-zero is answered locally
// without touching the divider.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid [N_REQ]      per-requester request valid
//   req_a/req_b [N_REQ*W]  flattened operands, requester i at [i*W +: W]
//   req_ready [N_REQ]      one-hot accept pulse
//   div_start              one-cycle divider start pulse
//   div_a/div_b [W]        operands to the divider, held until done
//   div_q/div_r [W]        divider results, valid with div_done
//   div_done               divider completion
//   rsp_valid/rsp_ready    response handshake
//   rsp_id                 index of the requester the response belongs to
//   rsp_q/rsp_r [W]        quotient / remainder
//   rsp_dbz, rsp_err       divide-by-zero flag, divider timeout flag
// -----------------------------------------------------------------------------
module div_scheduler
    import div_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned W       = W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*W-1:0]       req_a,
    input  logic [N_REQ*W-1:0]       req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     div_start,
    output logic [W-1:0]             div_a,
    output logic [W-1:0]             div_b,
    input  logic [W-1:0]             div_q,
    input  logic [W-1:0]             div_r,
    input  logic                     div_done,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [W-1:0]             rsp_q,
    output logic [W-1:0]             rsp_r,
    output logic                     rsp_dbz,
    output logic                     rsp_err
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [IW-1:0] r_id;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_r;
    logic          r_dbz;
    logic          r_err;

    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0]    w_idx;
    logic [W-1:0]     w_a_sel;
    logic [W-1:0]     w_b_sel;
    logic             w_accept;
    logic             w_timeout;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_a_sel = req_a[w_idx*W +: W];
    assign w_b_sel = req_b[w_idx*W +: W];

    // Acceptance is suppressed while reset is asserted so no requester sees
    // a ready pulse for a request that the reset would then discard.
    assign w_accept  = (r_state == IDLE) && (|req_valid) && !rst;
    // Counter holds the number of done-less WAIT cycles already spent; this
    // cycle is the TIMEOUT-th one.
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        div_start = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = w_accept ? w_grant : '0;
                if (w_accept) begin
                    w_next = (w_b_sel == '0) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                div_start = 1'b1;
                w_next    = WAIT;
            end
            WAIT: begin
                if (div_done || w_timeout) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_id  <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_dbz <= 1'b0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ptr <= (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
                        r_id  <= w_idx;
                        r_a   <= w_a_sel;
                        r_b   <= w_b_sel;
                        if (w_b_sel == '0) begin
                            r_q   <= '1;
                            r_r   <= w_a_sel;
                            r_dbz <= 1'b1;
                            r_err <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt <= '0;
                end
                WAIT: begin
                    // done is checked first so it wins over a coincident timeout.
                    if (div_done) begin
                        r_q   <= div_q;
                        r_r   <= div_r;
                        r_dbz <= 1'b0;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_q   <= '0;
                        r_r   <= '0;
                        r_dbz <= 1'b0;
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_a   = r_a;
    assign div_b   = r_b;
    assign rsp_id  = r_id;
    assign rsp_q   = r_q;
    assign rsp_r   = r_r;
    assign rsp_dbz = r_dbz;
    assign rsp_err = r_err;

endmodule

// File: tb/tb_div_scheduler.sv
// -----------------------------------------------------------------------------
// tb_div_scheduler
// Directed bench for div_scheduler with an external divider model of
// configurable latency (0 = never completes). A transaction-level model
// predicts, per cycle, ready/start/valid and the response contents from the
// latency rules; a response log is also pinned against hand-computed values.
// -----------------------------------------------------------------------------
module tb_div_scheduler;

    localparam int N  = 4;
    localparam int W  = 7;
    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           div_start;
    logic [W-1:0]   div_a, div_b, div_q, div_r;
    logic           div_done;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_q, rsp_r;
    logic           rsp_dbz, rsp_err;

    div_scheduler #(
        .N_REQ   (N),
        .W       (W),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_q     (div_q),
        .div_r     (div_r),
        .div_done  (div_done),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_dbz   (rsp_dbz),
        .rsp_err   (rsp_err)
    );

    // ---------------- requesters ----------------
    int op_a [N] = '{default: 0};
    int op_b [N] = '{default: 0};
    int post [N] = '{default: 0};
    int acc  [N] = '{default: 0};

    for (genvar g = 0; g < N; g++) begin : g_ops
        assign req_a[g*W +: W] = op_a[g][W-1:0];
        assign req_b[g*W +: W] = op_b[g][W-1:0];
    end

    // ---------------- divider model ----------------
    int         lat = 8;
    int         dv_k = 0;
    logic [W-1:0] da = '0, db = '1;
    logic       dv_done = 1'b0;
    logic       spur_done = 1'b0;
    assign div_done = dv_done | spur_done;
    assign div_q = dv_done ? (da / db) : 7'h2A;
    assign div_r = dv_done ? (da % db) : 7'h15;

    // ---------------- bookkeeping ----------------
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int vlat = 0;
    int st_cnt = 0;
    logic prev_v = 1'b0;
    logic [N-1:0] rdy_seen = '0;
    logic st_seen = 1'b0;

    typedef struct {
        int id; int q; int r; int dbz; int err; int lat;
    } rsp_t;
    rsp_t rlog[$];

    // model state
    bit m_armed = 0, m_busy = 0, m_post_rst = 0;
    int m_ptr = 0, m_t = 0, m_id = 0, m_a = 0, m_b = 0;
    int m_q = 0, m_r = 0, m_dbz = 0, m_err = 0, m_resp_at = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Input driver and divider: act 1 time unit after the rising edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) if (rdy_seen[i]) acc[i]++;
        for (int i = 0; i < N; i++) req_valid[i] = (post[i] != acc[i]);
        if (st_seen) begin
            dv_k = 1;
            da = div_a;
            db = div_b;
        end else if (dv_k != 0 && dv_k < 1000) begin
            dv_k++;
        end
        dv_done = (lat != 0) && (dv_k == lat);
    end

    // Compare process: sample on falling edge, then advance the model.
    always @(negedge clk) begin : cmp
        int w;
        int idx;
        logic [N-1:0] e_rdy;
        logic e_start, e_valid;
        cyc++;
        w = -1;
        e_rdy = '0;
        e_start = 1'b0;
        e_valid = 1'b0;
        if (!m_busy) begin
            if (!rst) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (w < 0 && req_valid[idx]) w = idx;
                end
            end
            if (w >= 0) e_rdy[w] = 1'b1;
        end else begin
            e_start = (m_b != 0) && (m_t == 1);
            e_valid = (m_t >= m_resp_at);
        end

        if (m_armed) begin
            check("req_ready", int'(req_ready), int'(e_rdy));
            check("div_start", int'(div_start), int'(e_start));
            check("rsp_valid", int'(rsp_valid), int'(e_valid));
            if (e_valid) begin
                check("rsp_id",  int'(rsp_id),  m_id);
                check("rsp_q",   int'(rsp_q),   m_q);
                check("rsp_r",   int'(rsp_r),   m_r);
                check("rsp_dbz", int'(rsp_dbz), m_dbz);
                check("rsp_err", int'(rsp_err), m_err);
            end
            if (m_busy && !e_valid && m_t >= 1) begin
                check("div_a_hold", int'(div_a), m_a);
                check("div_b_hold", int'(div_b), m_b);
            end
            if (m_post_rst) begin
                check("rst_div_a",   int'(div_a),   0);
                check("rst_div_b",   int'(div_b),   0);
                check("rst_rsp_id",  int'(rsp_id),  0);
                check("rst_rsp_q",   int'(rsp_q),   0);
                check("rst_rsp_r",   int'(rsp_r),   0);
                check("rst_rsp_dbz", int'(rsp_dbz), 0);
                check("rst_rsp_err", int'(rsp_err), 0);
            end
        end

        rdy_seen = req_ready;
        st_seen = div_start;
        if (div_start) st_cnt++;
        if (|req_ready) acc_cyc = cyc;
        if (rsp_valid && !prev_v) vlat = cyc - acc_cyc;
        prev_v = rsp_valid;
        if (rsp_valid && rsp_ready && !rst)
            rlog.push_back('{int'(rsp_id), int'(rsp_q), int'(rsp_r),
                             int'(rsp_dbz), int'(rsp_err), vlat});

        m_post_rst = 0;
        if (rst) begin
            m_armed = 1;
            m_busy = 0;
            m_ptr = 0;
            m_post_rst = 1;
        end else if (!m_busy) begin
            if (w >= 0) begin
                m_busy = 1;
                m_t = 1;
                m_id = w;
                m_a = op_a[w];
                m_b = op_b[w];
                m_ptr = (w + 1) % N;
                m_dbz = 0;
                m_err = 0;
                if (m_b == 0) begin
                    m_resp_at = 1;
                    m_q = (1 << W) - 1;
                    m_r = m_a;
                    m_dbz = 1;
                end else if (lat != 0 && lat <= TO) begin
                    m_resp_at = lat + 2;
                    m_q = m_a / m_b;
                    m_r = m_a % m_b;
                end else begin
                    m_resp_at = TO + 2;
                    m_q = 0;
                    m_r = 0;
                    m_err = 1;
                end
            end
        end else if (m_t >= m_resp_at && rsp_ready) begin
            m_busy = 0;
        end else begin
            m_t++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic post_req(input int i, input int a, input int b);
        op_a[i] = a;
        op_b[i] = b;
        post[i]++;
    endtask

    task automatic wait_rsp(input int n);
        int k;
        k = 0;
        while (rlog.size() < n && k < 400) begin
            tick(1);
            k++;
        end
        if (rlog.size() < n) check("rsp_wait_budget", rlog.size(), n);
    endtask

    task automatic chk_log(input int i, input int id, input int q, input int r,
                           input int dbz, input int err, input int lt);
        if (i < rlog.size()) begin
            check("log_id",  rlog[i].id,  id);
            check("log_q",   rlog[i].q,   q);
            check("log_r",   rlog[i].r,   r);
            check("log_dbz", rlog[i].dbz, dbz);
            check("log_err", rlog[i].err, err);
            check("log_lat", rlog[i].lat, lt);
        end else begin
            check("log_missing", rlog.size(), i + 1);
        end
    endtask

    localparam int RR_A [N] = '{10, 20, 63, 100};
    localparam int RR_B [N] = '{3, 6, 8, 15};
    localparam int RR_Q [N] = '{3, 3, 7, 6};
    localparam int RR_R [N] = '{1, 2, 7, 10};

    initial begin : stim
        int s0, s1, n0, k;
        rst = 1'b1;
        rsp_ready = 1'b1;
        lat = 8;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Spurious done while idle must be ignored.
        spur_done = 1'b1;
        tick(1);
        spur_done = 1'b0;
        tick(2);

        // Single request.
        post_req(0, 50, 7);
        wait_rsp(1);
        chk_log(0, 0, 7, 1, 0, 0, 10);

        // Round robin from reset.
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < N; i++) post_req(i, RR_A[i], RR_B[i]);
        wait_rsp(5);
        for (int i = 0; i < N; i++) chk_log(1 + i, i, RR_Q[i], RR_R[i], 0, 0, 10);

        // Divide by zero.
        tick(2);
        s0 = st_cnt;
        post_req(2, 35, 0);
        wait_rsp(6);
        chk_log(5, 2, 127, 35, 1, 0, 1);
        check("dbz_no_start", st_cnt - s0, 0);

        // Backpressure with a competing request and a spurious done in RESP.
        tick(2);
        rsp_ready = 1'b0;
        post_req(1, 90, 9);
        k = 0;
        while (!rsp_valid && k < 40) begin
            tick(1);
            k++;
        end
        check("bp_valid_seen", int'(rsp_valid), 1);
        post_req(3, 17, 5);
        s0 = st_cnt;
        tick(2);
        spur_done = 1'b1;
        tick(1);
        spur_done = 1'b0;
        tick(2);
        check("bp_no_start", st_cnt - s0, 0);
        check("bp_no_rsp", rlog.size(), 6);
        rsp_ready = 1'b1;
        wait_rsp(8);
        chk_log(6, 1, 10, 0, 0, 0, 10);
        chk_log(7, 3, 3, 2, 0, 0, 10);

        // Timeout, then a normal request.
        tick(2);
        lat = 0;
        post_req(0, 40, 3);
        wait_rsp(9);
        chk_log(8, 0, 0, 0, 0, 1, TO + 2);
        lat = 8;
        post_req(1, 45, 6);
        wait_rsp(10);
        chk_log(9, 1, 7, 3, 0, 0, 10);

        // Done on the last WAIT cycle wins; one cycle later is a timeout.
        tick(2);
        lat = TO;
        post_req(2, 99, 10);
        wait_rsp(11);
        chk_log(10, 2, 9, 9, 0, 0, TO + 2);
        tick(2);
        lat = TO + 1;
        post_req(2, 99, 10);
        wait_rsp(12);
        chk_log(11, 2, 0, 0, 0, 1, TO + 2);

        // Reset three cycles after start; the late done must be ignored.
        tick(2);
        lat = 8;
        s0 = st_cnt;
        post_req(1, 77, 4);
        k = 0;
        while (st_cnt == s0 && k < 20) begin
            tick(1);
            k++;
        end
        check("rstw_start_seen", st_cnt - s0, 1);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        s1 = st_cnt;
        n0 = rlog.size();
        tick(12);
        check("rstw_no_rsp", rlog.size(), n0);
        check("rstw_no_start", st_cnt - s1, 0);
        post_req(3, 77, 4);
        post_req(0, 30, 7);
        wait_rsp(n0 + 2);
        chk_log(n0, 0, 4, 2, 0, 0, 10);
        chk_log(n0 + 1, 3, 19, 1, 0, 0, 10);

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
